// File: rtl/sort_engine.sv
// Four-entry odd-even transposition sorter: captures four values on start,
// runs four compare-exchange passes, then publishes the ordered result, swap count and a done pulse.
module sort_engine #(
    parameter int WIDTH     = 4,
    parameter bit ASCENDING = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_unsorted_num0,
    input  logic [WIDTH-1:0] i_unsorted_num1,
    input  logic [WIDTH-1:0] i_unsorted_num2,
    input  logic [WIDTH-1:0] i_unsorted_num3,
    output logic [WIDTH-1:0] o_sorted_num0,
    output logic [WIDTH-1:0] o_sorted_num1,
    output logic [WIDTH-1:0] o_sorted_num2,
    output logic [WIDTH-1:0] o_sorted_num3,
    output logic [2:0]       o_swap_count,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SORT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       r_pass_cnt;
    logic [2:0]       r_acc;
    logic [WIDTH-1:0] r_work [4];
    logic [WIDTH-1:0] r_sorted [4];
    logic [2:0]       r_swap_count;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_work [4];
    logic             w_sw01;
    logic             w_sw12;
    logic             w_sw23;
    logic [1:0]       w_pass_swaps;

    // Strictly out of order only, so equal values stay put and the sort is stable.
    function automatic logic out_of_order(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return ASCENDING ? (a > b) : (a < b);
    endfunction

    // One compare-exchange pass: even passes pair (0,1)/(2,3), odd passes pair (1,2).
    always_comb begin
        w_sw01       = ~r_pass_cnt[0] & out_of_order(r_work[0], r_work[1]);
        w_sw23       = ~r_pass_cnt[0] & out_of_order(r_work[2], r_work[3]);
        w_sw12       =  r_pass_cnt[0] & out_of_order(r_work[1], r_work[2]);
        w_work[0]    = w_sw01 ? r_work[1] : r_work[0];
        w_work[1]    = w_sw01 ? r_work[0] : (w_sw12 ? r_work[2] : r_work[1]);
        w_work[2]    = w_sw23 ? r_work[3] : (w_sw12 ? r_work[1] : r_work[2]);
        w_work[3]    = w_sw23 ? r_work[2] : r_work[3];
        w_pass_swaps = {1'b0, w_sw01} + {1'b0, w_sw12} + {1'b0, w_sw23};
    end

    // Control FSM, working registers and registered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_pass_cnt   <= 2'd0;
            r_acc        <= 3'd0;
            r_work[0]    <= '0;
            r_work[1]    <= '0;
            r_work[2]    <= '0;
            r_work[3]    <= '0;
            r_sorted[0]  <= '0;
            r_sorted[1]  <= '0;
            r_sorted[2]  <= '0;
            r_sorted[3]  <= '0;
            r_swap_count <= 3'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_work[0]  <= i_unsorted_num0;
                        r_work[1]  <= i_unsorted_num1;
                        r_work[2]  <= i_unsorted_num2;
                        r_work[3]  <= i_unsorted_num3;
                        r_pass_cnt <= 2'd0;
                        r_acc      <= 3'd0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SORT;
                    end
                end
                ST_SORT: begin
                    r_work     <= w_work;
                    r_acc      <= r_acc + {1'b0, w_pass_swaps};
                    r_pass_cnt <= r_pass_cnt + 2'd1;
                    if (r_pass_cnt == 2'd3) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_sorted     <= r_work;
                    r_swap_count <= r_acc;
                    r_done       <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_sorted_num0 = r_sorted[0];
    assign o_sorted_num1 = r_sorted[1];
    assign o_sorted_num2 = r_sorted[2];
    assign o_sorted_num3 = r_sorted[3];
    assign o_swap_count  = r_swap_count;
    assign o_busy        = r_busy;
    assign o_done        = r_done;

endmodule
